// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID and timestamp words
// and compares them against the values the software build expects.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd28,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1718188374,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        autoPending_q;
    logic [15:0] count_q, count_d;
    logic [15:0] countNext;
    logic        expired;
    logic        clearResults;
    logic        idMismatch_q, idMismatch_d;
    logic        tsMismatch_q, tsMismatch_d;
    logic        timeout_q, timeout_d;
    logic [31:0] idValue_q, idValue_d;
    logic [31:0] tsValue_q, tsValue_d;

    // The counter holds the cycles already spent on the current transfer, so
    // expiry fires on the TIMEOUT_CYCLES-th cycle unless data is captured then.
    assign countNext = count_q + 16'd1;
    assign expired   = (countNext >= TIMEOUT_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            autoPending_q <= AUTO_START;
            count_q       <= '0;
            idMismatch_q  <= 1'b0;
            tsMismatch_q  <= 1'b0;
            timeout_q     <= 1'b0;
            idValue_q     <= '0;
            tsValue_q     <= '0;
        end else begin
            state_q       <= state_d;
            autoPending_q <= 1'b0;
            count_q       <= count_d;
            idMismatch_q  <= idMismatch_d;
            tsMismatch_q  <= tsMismatch_d;
            timeout_q     <= timeout_d;
            idValue_q     <= idValue_d;
            tsValue_q     <= tsValue_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idMismatch_d = idMismatch_q;
        tsMismatch_d = tsMismatch_q;
        timeout_d    = timeout_q;
        idValue_d    = idValue_q;
        tsValue_d    = tsValue_q;
        clearResults = 1'b0;

        case (state_q)
            IDLE: begin
                if (start || autoPending_q) begin
                    state_d      = REQ_ID;
                    clearResults = 1'b1;
                end
            end
            REQ_ID: begin
                count_d = countNext;
                if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else if (!avm_waitrequest) begin
                    state_d = WAIT_ID;
                end
            end
            // A response landing on the expiry cycle still counts as captured.
            WAIT_ID: begin
                count_d = countNext;
                if (avm_readdatavalid) begin
                    idValue_d    = avm_readdata;
                    idMismatch_d = (avm_readdata != EXPECTED_ID);
                    count_d      = '0;
                    state_d      = REQ_TS;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            REQ_TS: begin
                count_d = countNext;
                if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else if (!avm_waitrequest) begin
                    state_d = WAIT_TS;
                end
            end
            WAIT_TS: begin
                count_d = countNext;
                if (avm_readdatavalid) begin
                    tsValue_d    = avm_readdata;
                    tsMismatch_d = (avm_readdata != EXPECTED_TIMESTAMP);
                    state_d      = DONE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d      = REQ_ID;
                    clearResults = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clearResults) begin
            count_d      = '0;
            idMismatch_d = 1'b0;
            tsMismatch_d = 1'b0;
            timeout_d    = 1'b0;
            idValue_d    = '0;
            tsValue_d    = '0;
        end
    end

    assign avm_read    = (state_q == REQ_ID) || (state_q == REQ_TS);
    assign avm_address = (state_q == REQ_TS);
    assign busy        = (state_q == REQ_ID) || (state_q == WAIT_ID) ||
                         (state_q == REQ_TS) || (state_q == WAIT_TS);
    assign done        = (state_q == DONE);
    assign pass        = done && !idMismatch_q && !tsMismatch_q && !timeout_q;
    assign id_mismatch = idMismatch_q;
    assign ts_mismatch = tsMismatch_q;
    assign timeout     = timeout_q;
    assign id_value    = idValue_q;
    assign ts_value    = tsValue_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: a behavioural Avalon slave, a transfer-level
// reference model feeding an expectation queue, and a monitor that checks each completion.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd28;
    localparam logic [31:0] EXP_TS = 32'd1718188374;
    localparam int          TMO    = 8;
    localparam int          STUCK  = 100000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] id_value, ts_value;

    sysid_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES    (TMO),
        .AUTO_START        (1'b1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .id_mismatch      (id_mismatch),
        .ts_mismatch      (ts_mismatch),
        .timeout          (timeout),
        .id_value         (id_value),
        .ts_value         (ts_value)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        pass;
        logic        idMm;
        logic        tsMm;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          doneCyc;
        int          rd0;
        int          rd1;
    } exp_t;

    resp_t       respQ[$];
    exp_t        expQ[$];
    int          cfgWait[2];
    int          cfgLat[2];
    logic [31:0] cfgData[2];
    int          rdCycles[2];
    int          addrChanged = 0;
    bit          injectStray = 1'b0;
    logic [31:0] strayData = 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_ctrl"},
                    {24'd0, avm_read, avm_address, busy, done, pass,
                     id_mismatch, ts_mismatch, timeout}, 32'd0);
        checkOutput({name, "_id_value"}, id_value, 32'd0);
        checkOutput({name, "_ts_value"}, ts_value, 32'd0);
    endtask

    task automatic setCfg(input int w0, input int l0, input int w1, input int l1,
                          input logic [31:0] d0, input logic [31:0] d1);
        cfgWait[0] = w0; cfgLat[0] = l0; cfgData[0] = d0;
        cfgWait[1] = w1; cfgLat[1] = l1; cfgData[1] = d1;
    endtask

    // A read lasts waits+1 request cycles plus the latency; it is captured only
    // if that total fits within the timeout window, otherwise the check aborts.
    function automatic exp_t predict(input int s);
        exp_t e;
        int   k0, k1;
        e = '{default: 0};
        k0 = cfgWait[0] + 1 + cfgLat[0];
        k1 = cfgWait[1] + 1 + cfgLat[1];
        e.rd0 = (cfgWait[0] + 1 < TMO) ? cfgWait[0] + 1 : TMO;
        if (k0 > TMO) begin
            e.tmo     = 1'b1;
            e.doneCyc = s + TMO + 1;
        end else begin
            e.idv  = cfgData[0];
            e.idMm = (cfgData[0] != EXP_ID);
            e.rd1  = (cfgWait[1] + 1 < TMO) ? cfgWait[1] + 1 : TMO;
            if (k1 > TMO) begin
                e.tmo     = 1'b1;
                e.doneCyc = s + k0 + TMO + 1;
            end else begin
                e.tsv     = cfgData[1];
                e.tsMm    = (cfgData[1] != EXP_TS);
                e.doneCyc = s + k0 + k1 + 1;
            end
        end
        e.pass = !e.tmo && !e.idMm && !e.tsMm;
        return e;
    endfunction

    task automatic clearTally();
        rdCycles[0] = 0;
        rdCycles[1] = 0;
        addrChanged = 0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_wait: done never rose within %0d cycles", n);
        end
    endtask

    task automatic applyStimulus(input bit pulseBusy);
        @(negedge clock);
        start = 1'b1;
        clearTally();
        expQ.push_back(predict(cyc));
        @(negedge clock);
        start = 1'b0;
        checkOutput("restart_clears_flags",
                    {27'd0, done, pass, timeout, id_mismatch, ts_mismatch}, 32'd0);
        checkOutput("restart_clears_id", id_value, 32'd0);
        if (pulseBusy) begin
            @(negedge clock);
            start = 1'b1;
            checkOutput("busy_mid_check", {31'd0, busy}, 32'd1);
            @(negedge clock);
            start = 1'b0;
        end
        waitDone();
        repeat (6) @(negedge clock);
    endtask

    // Behavioural slave: stalls each read for cfgWait cycles, answers cfgLat later.
    initial begin : slave
        int   waitCnt;
        bit   reqActive;
        logic reqAddr;
        int   idx;
        waitCnt   = 0;
        reqActive = 1'b0;
        reqAddr   = 1'b0;
        forever begin
            @(negedge clock);
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (respQ.size() > 0 && respQ[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = respQ[0].data;
                respQ.delete(0);
            end else if (injectStray) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = strayData;
                injectStray       = 1'b0;
            end
            if (avm_read === 1'b1) begin
                idx = (avm_address === 1'b1) ? 1 : 0;
                rdCycles[idx]++;
                if (reqActive && avm_address !== reqAddr) addrChanged++;
                reqActive = 1'b1;
                reqAddr   = avm_address;
                if (waitCnt < cfgWait[idx]) begin
                    avm_waitrequest = 1'b1;
                    waitCnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    respQ.push_back('{due: cyc + cfgLat[idx], data: cfgData[idx]});
                    waitCnt   = 0;
                    reqActive = 1'b0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                waitCnt         = 0;
                reqActive       = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit   prevDone;
        exp_t e;
        prevDone = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (done === 1'b1 && !prevDone) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: done rose at cycle %0d with no check pending", cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_cycle", cyc, e.doneCyc);
                    checkOutput("pass", {31'd0, pass}, {31'd0, e.pass});
                    checkOutput("id_mismatch", {31'd0, id_mismatch}, {31'd0, e.idMm});
                    checkOutput("ts_mismatch", {31'd0, ts_mismatch}, {31'd0, e.tsMm});
                    checkOutput("timeout", {31'd0, timeout}, {31'd0, e.tmo});
                    checkOutput("id_value", id_value, e.idv);
                    checkOutput("ts_value", ts_value, e.tsv);
                    checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
                    checkOutput("id_read_cycles", rdCycles[0], e.rd0);
                    checkOutput("ts_read_cycles", rdCycles[1], e.rd1);
                    checkOutput("address_stable", addrChanged, 32'd0);
                end
            end
            prevDone = (done === 1'b1);
        end
    end

    initial begin : stimulus
        int          s;
        int          w0, l0, w1, l1;
        logic [31:0] d0, d1;

        // Power-on reset followed by the automatic check on a clean slave.
        setCfg(0, 1, 0, 1, EXP_ID, EXP_TS);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkAllZero("reset_state");
        reset = 1'b0;
        s = cyc;
        clearTally();
        expQ.push_back(predict(s));
        @(negedge clock);
        checkOutput("auto_read_id", {30'd0, avm_read, avm_address}, 32'd2);
        repeat (2) @(negedge clock);
        checkOutput("auto_read_ts", {30'd0, avm_read, avm_address}, 32'd3);
        waitDone();
        repeat (6) @(negedge clock);

        setCfg(0, 1, 0, 1, 32'd29, EXP_TS);
        applyStimulus(1'b0);
        setCfg(3, 2, 3, 2, EXP_ID, EXP_TS);
        applyStimulus(1'b0);
        setCfg(STUCK, 1, 0, 1, EXP_ID, EXP_TS);
        applyStimulus(1'b0);
        setCfg(0, 1, 3, 4, EXP_ID, 32'd12345);
        applyStimulus(1'b0);
        setCfg(0, 1, 4, 4, EXP_ID, EXP_TS);
        applyStimulus(1'b0);
        setCfg(1, 1, 0, 2, EXP_ID, EXP_TS);
        applyStimulus(1'b1);

        // Stray response while parked in DONE must not disturb the results.
        injectStray = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("stray_id_value", id_value, EXP_ID);
        checkOutput("stray_still_done", {31'd0, done}, 32'd1);

        // Reset during WAIT_TS; the late response must be ignored and auto-start rerun.
        setCfg(0, 1, 0, 3, EXP_ID, EXP_TS);
        @(negedge clock);
        start = 1'b1;
        clearTally();
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("busy_in_wait_ts", {30'd0, busy, avm_read}, 32'd2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkAllZero("reset_mid_transfer");
        clearTally();
        expQ.push_back(predict(cyc));
        waitDone();
        repeat (6) @(negedge clock);

        for (int i = 0; i < 24; i++) begin
            w0 = ($urandom_range(0, 9) == 0) ? STUCK : int'($urandom_range(0, 4));
            w1 = ($urandom_range(0, 9) == 0) ? STUCK : int'($urandom_range(0, 4));
            l0 = int'($urandom_range(1, 4));
            l1 = int'($urandom_range(1, 4));
            d0 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
            d1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS;
            setCfg(w0, l0, w1, l1, d0, d1);
            applyStimulus(1'($urandom_range(0, 1)));
        end

        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pending_checks: %0d expected completions never observed", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
